// File: rtl/mult_pkg.sv
// Shared types and constants for the shift-add multiplier sequencer.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 8;

  // Counter must reach WIDTH (the final-add cycle), so it needs clog2(WIDTH+1) bits.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/mult_pp_row.sv
// Registered partial-product row: one AND row, one flop of latency.
module mult_pp_row
  import mult_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a_row,
  input  logic             bit_sel,
  output logic [WIDTH-1:0] row_q
);

  // Gate the multiplicand by the selected multiplier bit and register it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) row_q <= '0;
    else      row_q <= a_row & {WIDTH{bit_sel}};
  end

endmodule

// File: rtl/mult_shift_add_seq.sv
// Iterative unsigned shift-add multiplier: one partial-product row per cycle,
// accumulated into a 2*WIDTH product returned over valid/ready.
module mult_shift_add_seq
  import mult_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  localparam int CW = cnt_width(WIDTH);
  localparam int PW = 2 * WIDTH;

  state_t           state, state_nx;
  logic [CW-1:0]    cnt;
  logic [PW-1:0]    acc;
  logic [WIDTH-1:0] a_reg, b_reg, pp_reg;
  logic             accept, last, bit_sel;

  assign accept = (state == IDLE) && in_valid;
  assign last   = (state == RUN) && (cnt == CW'(WIDTH));
  // Outside RUN (and at the final-add cycle) the row loads zero, so pp_reg is
  // already clear when an operation is accepted.
  assign bit_sel = (state == RUN) && (cnt < CW'(WIDTH)) &&
                   (|(b_reg & (WIDTH'(1) << cnt)));

  mult_pp_row #(.WIDTH(WIDTH)) u_row (
    .clk     (clk),
    .rst     (rst),
    .a_row   (a_reg),
    .bit_sel (bit_sel),
    .row_q   (pp_reg)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // Next-state and handshake decode.
  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_nx = RUN;
      end
      RUN: begin
        if (last) state_nx = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
        busy     = 1'b0;
      end
    endcase
  end

  // Operand capture, step counter and accumulator. The row registered at
  // cnt-1 is added at cnt, so RUN spans WIDTH+1 cycles with no early exit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt   <= '0;
      acc   <= '0;
      a_reg <= '0;
      b_reg <= '0;
    end else if (accept) begin
      a_reg <= a;
      b_reg <= b;
      cnt   <= '0;
      acc   <= '0;
    end else if (state == RUN) begin
      cnt <= cnt + CW'(1);
      if (cnt != '0) acc <= acc + (PW'(pp_reg) << (cnt - CW'(1)));
    end
  end

  // Product tracks the accumulator; it holds through DONE and IDLE until
  // the next acceptance clears it.
  assign product = acc;

endmodule

// File: tb/tb_mult_shift_add_seq.sv
// Self-checking bench: WIDTH=8 directed + random, WIDTH=4 random, with a
// per-instance scoreboard queue filled on accept and drained on output.
module tb_mult_shift_add_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        iv[2];
  logic [7:0]  ta[2];
  logic [7:0]  tbv[2];
  logic        ordy_dir[2];
  logic        ordy_rnd[2];
  logic        rnd_en;
  logic        ordy0, ordy1;
  logic        ir8, ov8, bsy8, ir4, ov4, bsy4;
  logic [15:0] prod8;
  logic [7:0]  prod4;
  int          n_chk = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  assign ordy0 = rnd_en ? ordy_rnd[0] : ordy_dir[0];
  assign ordy1 = rnd_en ? ordy_rnd[1] : ordy_dir[1];

  mult_shift_add_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir8),
    .a(ta[0]), .b(tbv[0]), .out_valid(ov8), .out_ready(ordy0),
    .product(prod8), .busy(bsy8)
  );

  mult_shift_add_seq #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir4),
    .a(ta[1][3:0]), .b(tbv[1][3:0]), .out_valid(ov4), .out_ready(ordy1),
    .product(prod4), .busy(bsy4)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic get_ir(input int i);
    return (i == 0) ? ir8 : ir4;
  endfunction

  function automatic logic get_ov(input int i);
    return (i == 0) ? ov8 : ov4;
  endfunction

  // Scoreboard/monitor per instance, sampled on the falling edge.
  for (genvar gi = 0; gi < 2; gi++) begin : g_mon
    localparam int W = (gi == 0) ? 8 : 4;
    localparam logic [7:0] MASK = 8'((1 << W) - 1);
    logic [31:0] q[$];
    int          cyc = 0;
    int          acc_cyc = 0;
    logic        pv = 1'b0;
    logic        held = 1'b0;
    logic [15:0] pp = '0;
    wire         v    = (gi == 0) ? ov8 : ov4;
    wire         r    = (gi == 0) ? ir8 : ir4;
    wire         ordy = (gi == 0) ? ordy0 : ordy1;
    wire [15:0]  p    = (gi == 0) ? prod8 : {8'h00, prod4};

    always @(negedge clk) begin
      cyc++;
      if (!rst) begin
        q.delete();
        pv   = 1'b0;
        held = 1'b0;
      end else begin
        if (held) begin
          chk($sformatf("w%0d_valid_held", W), 32'(v), 32'd1);
          chk($sformatf("w%0d_product_hold", W), 32'(p), 32'(pp));
        end
        if (v && !pv) chk($sformatf("w%0d_latency", W), 32'(cyc - acc_cyc - 1), 32'(W + 1));
        if (v && ordy) begin
          chk($sformatf("w%0d_out_has_expect", W), 32'(q.size() > 0), 32'd1);
          if (q.size() > 0) chk($sformatf("w%0d_product", W), 32'(p), q.pop_front());
        end
        if (iv[gi] && r) begin
          q.push_back(32'(ta[gi] & MASK) * 32'(tbv[gi] & MASK));
          acc_cyc = cyc;
        end
        pv   = v;
        held = v && !ordy;
        pp   = p;
      end
    end
  end

  // Random backpressure, only routed to the DUTs during the random phase.
  always @(posedge clk) begin
    #1;
    ordy_rnd[0] = ($urandom_range(0, 3) != 0);
    ordy_rnd[1] = ($urandom_range(0, 3) != 0);
  end

  task automatic send(input int i, input logic [7:0] av, input logic [7:0] bv);
    int t = 0;
    while (!get_ir(i) && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 200) chk("in_ready_timeout", 32'(get_ir(i)), 32'd1);
    iv[i] = 1'b1; ta[i] = av; tbv[i] = bv;
    @(posedge clk); #1;
    iv[i] = 1'b0;
  endtask

  task automatic wait_valid(input int i);
    int t = 0;
    while (!get_ov(i) && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 50) chk("out_valid_timeout", 32'(get_ov(i)), 32'd1);
  endtask

  task automatic run_rand(input int i, input int n);
    int mx = (i == 0) ? 255 : 15;
    for (int k = 0; k < n; k++)
      send(i, 8'($urandom_range(0, mx)), 8'($urandom_range(0, mx)));
  endtask

  initial begin
    int   t;
    logic bad;
    rst = 1'b0; rnd_en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      iv[i] = 1'b0; ta[i] = '0; tbv[i] = '0; ordy_dir[i] = 1'b1; ordy_rnd[i] = 1'b1;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(ov8), 32'd0);
    chk("rst_product", 32'(prod8), 32'd0);
    chk("rst_busy", 32'(bsy8), 32'd0);
    chk("rst_in_ready", 32'(ir8), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;

    // Max operands; in_ready must stay low until back in IDLE.
    send(0, 8'hFF, 8'hFF);
    bad = 1'b0; t = 0;
    while (!ov8 && t < 50) begin
      if (ir8) bad = 1'b1;
      @(posedge clk); #1;
      t++;
    end
    chk("in_ready_low_run", 32'(bad), 32'd0);
    chk("busy_in_done", 32'(bsy8), 32'd1);
    @(posedge clk); #1;
    chk("idle_after_ack", 32'(ir8), 32'd1);

    // Zero multiplicand: full latency still applies.
    send(0, 8'h00, 8'h5A);
    wait_valid(0);
    @(posedge clk); #1;

    // Backpressure for 5 cycles, then release.
    ordy_dir[0] = 1'b0;
    send(0, 8'h0D, 8'hB3);
    wait_valid(0);
    repeat (5) begin @(posedge clk); #1; end
    ordy_dir[0] = 1'b1;
    @(posedge clk); #1;
    chk("idle_one_edge", 32'(ir8), 32'd1);
    chk("out_valid_drop", 32'(ov8), 32'd0);

    // in_valid during RUN ignored; changing a/b after accept has no effect.
    send(0, 8'h12, 8'h34);
    repeat (3) begin @(posedge clk); #1; end
    iv[0] = 1'b1; ta[0] = 8'hAA; tbv[0] = 8'h55;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    wait_valid(0);
    @(posedge clk); #1;
    send(0, 8'hAA, 8'h55);
    wait_valid(0);
    @(posedge clk); #1;

    // Reset in the middle of RUN (cnt=4).
    send(0, 8'hC3, 8'h7E);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(ov8), 32'd0);
    chk("midrst_busy", 32'(bsy8), 32'd0);
    chk("midrst_in_ready", 32'(ir8), 32'd1);
    chk("midrst_product", 32'(prod8), 32'd0);
    repeat (3) begin @(posedge clk); #1; end
    chk("midrst_no_valid", 32'(ov8), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    send(0, 8'h03, 8'h05);
    wait_valid(0);
    @(posedge clk); #1;

    // Random operands with random backpressure on both widths.
    rnd_en = 1'b1;
    fork
      run_rand(0, 1000);
      run_rand(1, 1000);
    join
    t = 0;
    while ((g_mon[0].q.size() != 0 || g_mon[1].q.size() != 0) && t < 300) begin
      @(posedge clk); #1;
      t++;
    end
    chk("drain", 32'(g_mon[0].q.size() + g_mon[1].q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
